// File: rtl/mem_if_pkg.sv
// Shared command encodings and executor state for the DDR application-side interface.
// Imported by mem_resp and by the mem_sched command source.
package mem_if_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WD = 2'd1,
        REFRESH = 2'd2
    } exec_state_t;

    function automatic logic is_legal_cmd(input logic [2:0] c);
        return (c == CMD_WRITE) || (c == CMD_READ);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view (pop_data always shows the oldest entry).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

endmodule

// File: rtl/mem_resp.sv
// BRAM-backed stand-in for the DDR controller: queued commands, in-order execution, fixed read latency.
// Optional refresh-stall emulation is compiled in with MEM_RESP_REFRESH_EN.
module mem_resp
    import mem_if_pkg::*;
#(
    parameter int ADDR_BITS      = 10,
    parameter int DATA_WIDTH     = 64,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int WDF_DEPTH      = 4,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  app_en,
    input  logic [2:0]            cmd,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  mem_app_rdy,
    output logic                  mem_wr_rdy,
    output logic                  mem_rd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  cmd_err
);
    localparam int CMD_W = 3 + ADDR_BITS;

    exec_state_t           state_reg, state_next;
    logic                  ready_en_reg;
    logic                  cmd_err_reg, cmd_err_next;
    logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic                  wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic [CMD_W-1:0]      cmd_head;
    logic [DATA_WIDTH-1:0] wdf_head;
    logic [$clog2(CMD_FIFO_DEPTH):0] cmd_count;
    logic [$clog2(WDF_DEPTH):0]      wdf_count;
    logic                  unused_counts;
    logic [2:0]            head_cmd;
    logic [ADDR_BITS-1:0]  head_addr;
    logic                  ram_we, ram_re;
    logic                  refresh_block;

    assign head_cmd      = cmd_head[CMD_W-1 -: 3];
    assign head_addr     = cmd_head[ADDR_BITS-1:0];
    assign unused_counts = ^{cmd_count, wdf_count};

    // ready_en_reg keeps both readies low through reset and for the first cycle after it
    assign mem_app_rdy = ready_en_reg & ~cmd_full & ~refresh_block;
    assign mem_wr_rdy  = ready_en_reg & ~wdf_full;
    assign cmd_push    = app_en & mem_app_rdy;
    assign wdf_push    = mem_wr & mem_wr_rdy;
    assign cmd_err     = cmd_err_reg;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst(rst), .push(cmd_push), .push_data({cmd, addr}), .pop(cmd_pop),
        .pop_data(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk(clk), .rst(rst), .push(wdf_push), .push_data(wr_data), .pop(wdf_pop),
        .pop_data(wdf_head), .full(wdf_full), .empty(wdf_empty), .count(wdf_count)
    );

`ifdef MEM_RESP_REFRESH_EN
    localparam int RCNT_W  = $clog2(REFRESH_PERIOD + 1);
    localparam int STALL_W = $clog2(REFRESH_CYCLES + 1);

    logic [RCNT_W-1:0]  refresh_cnt_reg;
    logic [STALL_W-1:0] stall_cnt_reg;
    logic               refresh_due_reg;
    logic               refresh_wrap, refresh_exit;

    assign refresh_wrap  = (refresh_cnt_reg == RCNT_W'(REFRESH_PERIOD - 1));
    assign refresh_exit  = (state_reg == REFRESH) && (stall_cnt_reg == STALL_W'(REFRESH_CYCLES - 1));
    assign refresh_block = refresh_due_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_reg <= '0;
            refresh_due_reg <= 1'b0;
            stall_cnt_reg   <= '0;
        end else begin
            refresh_cnt_reg <= refresh_wrap ? '0 : refresh_cnt_reg + RCNT_W'(1);
            // a fresh wrap wins over the exit of a previous stall
            if (refresh_wrap)
                refresh_due_reg <= 1'b1;
            else if (refresh_exit)
                refresh_due_reg <= 1'b0;
            stall_cnt_reg <= (state_reg == REFRESH) ? stall_cnt_reg + STALL_W'(1) : '0;
        end
    end
`else
    localparam int unused_refresh_cfg = REFRESH_PERIOD + REFRESH_CYCLES;
    assign refresh_block = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cmd_err_next = cmd_err_reg;
        cmd_pop      = 1'b0;
        wdf_pop      = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cmd_empty) begin
                    if (head_cmd == CMD_WRITE) begin
                        if (!wdf_empty) begin
                            cmd_pop = 1'b1;
                            wdf_pop = 1'b1;
                            ram_we  = 1'b1;
                        end else begin
                            state_next = WAIT_WD;
                        end
                    end else if (is_legal_cmd(head_cmd)) begin
                        cmd_pop = 1'b1;
                        ram_re  = 1'b1;
                    end else begin
                        cmd_pop      = 1'b1;
                        cmd_err_next = 1'b1;
                    end
                end else if (refresh_block) begin
                    state_next = REFRESH;
                end
            end
            WAIT_WD: begin
                if (!wdf_empty) begin
                    cmd_pop    = 1'b1;
                    wdf_pop    = 1'b1;
                    ram_we     = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef MEM_RESP_REFRESH_EN
            REFRESH: begin
                if (refresh_exit)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cmd_err_reg  <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_err_reg  <= cmd_err_next;
            ready_en_reg <= 1'b1;
        end
    end

    // RAM is never reset so contents survive rst
    logic [DATA_WIDTH-1:0] ram_mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] ram_q_reg;
    logic                  issue_reg;

    always_ff @(posedge clk) begin
        if (ram_we && !rst)
            ram_mem[head_addr] <= wdf_head;
        if (ram_re)
            ram_q_reg <= ram_mem[head_addr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            issue_reg <= 1'b0;
        else
            issue_reg <= ram_re;
    end

    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
        logic                  v_reg;
        logic [DATA_WIDTH-1:0] d_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                v_reg <= rst ? 1'b0 : issue_reg;
                d_reg <= ram_q_reg;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                v_reg <= rst ? 1'b0 : g_rd_pipe[gi-1].v_reg;
                d_reg <= g_rd_pipe[gi-1].d_reg;
            end
        end
    end

    assign mem_rd_rdy = g_rd_pipe[RD_LATENCY-1].v_reg;
    assign rd_data    = mem_rd_rdy ? g_rd_pipe[RD_LATENCY-1].d_reg : '0;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: latency, pairing, backpressure, illegal commands, reset, optional refresh.
module tb_mem_resp;
    import mem_if_pkg::*;

    localparam int AW   = 10;
    localparam int DW   = 64;
    localparam int LAT  = 4;
    localparam int RCYC = 16;

    logic          clk = 1'b0, rst = 1'b1, app_en = 1'b0, mem_wr = 1'b0;
    logic [2:0]    cmd = 3'b000;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          mem_app_rdy, mem_wr_rdy, mem_rd_rdy, cmd_err;
    logic [DW-1:0] rd_data;

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [DW-1:0] rd_q[$];
    int            rd_cyc_q[$];

    mem_resp #(
        .ADDR_BITS(AW), .DATA_WIDTH(DW), .CMD_FIFO_DEPTH(4), .WDF_DEPTH(4),
        .RD_LATENCY(LAT), .REFRESH_PERIOD(32), .REFRESH_CYCLES(RCYC)
    ) dut (
        .clk(clk), .rst(rst), .app_en(app_en), .cmd(cmd), .addr(addr),
        .mem_wr(mem_wr), .wr_data(wr_data), .mem_app_rdy(mem_app_rdy),
        .mem_wr_rdy(mem_wr_rdy), .mem_rd_rdy(mem_rd_rdy), .rd_data(rd_data), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // read-return monitor: records data and edge index of every mem_rd_rdy pulse
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (mem_rd_rdy) begin
            rd_q.push_back(rd_data);
            rd_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_reads();
        rd_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
        int waited = 0;
        app_en = 1'b1; cmd = c; addr = a;
        while (!mem_app_rdy && waited < 100) begin
            step();
            waited++;
        end
        vectors++;
        if (mem_app_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: mem_app_rdy=%b after %0d cycles, required 1", mem_app_rdy, waited);
        end
        step();
        acc = cyc;
        app_en = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d);
        int waited = 0;
        mem_wr = 1'b1; wr_data = d;
        while (!mem_wr_rdy && waited < 100) begin
            step();
            waited++;
        end
        vectors++;
        if (mem_wr_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL data_accept: mem_wr_rdy=%b after %0d cycles, required 1", mem_wr_rdy, waited);
        end
        step();
        mem_wr = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 80 && rd_q.size() < n; i++) step();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (mem_app_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_app_rdy: got %b, required 0", mem_app_rdy); end
        vectors++;
        if (mem_wr_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_wr_rdy: got %b, required 0", mem_wr_rdy); end
        vectors++;
        if (mem_rd_rdy !== 1'b0 || rd_data !== '0) begin
            miscompares++; $display("FAIL reset_rd: rdy=%b data=%h, required 0/0", mem_rd_rdy, rd_data);
        end
        vectors++;
        if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_err: got %b, required 0", cmd_err); end
        rst = 1'b0;
        step();
        vectors++;
        if (mem_app_rdy !== 1'b1 || mem_wr_rdy !== 1'b1) begin
            miscompares++; $display("FAIL reset_release: app_rdy=%b wr_rdy=%b, required 1/1", mem_app_rdy, mem_wr_rdy);
        end
        $display("reset: done");
    endtask

    task automatic test_basic();
        int acc, r;
        clear_reads();
        send_cmd(CMD_WRITE, 10'd5, acc);
        send_data(64'hA5A5);
        send_cmd(CMD_READ, 10'd5, r);
        repeat (8) step();
        vectors++;
        if (rd_q.size() != 1) begin
            miscompares++; $display("FAIL basic_count: got %0d returns, required 1", rd_q.size());
        end else begin
            vectors++;
            if (rd_cyc_q[0] != r + 1 + LAT) begin
                miscompares++; $display("FAIL basic_latency: return at edge %0d, required %0d", rd_cyc_q[0], r + 1 + LAT);
            end
            vectors++;
            if (rd_q[0] !== 64'hA5A5) begin
                miscompares++; $display("FAIL basic_data: got %h, required %h", rd_q[0], 64'hA5A5);
            end
        end
        $display("basic: write/read addr 5, read accepted at edge %0d", r);
    endtask

    task automatic test_data_first();
        int acc, r;
        clear_reads();
        send_data(64'h11);
        send_data(64'h22);
        send_cmd(CMD_WRITE, 10'd1, acc);
        send_cmd(CMD_WRITE, 10'd2, acc);
        send_cmd(CMD_READ, 10'd2, r);
        send_cmd(CMD_READ, 10'd1, acc);
        repeat (9) step();
        vectors++;
        if (rd_q.size() != 2) begin
            miscompares++; $display("FAIL data_first_count: got %0d returns, required 2", rd_q.size());
        end else begin
            vectors++;
            if (rd_q[0] !== 64'h22 || rd_q[1] !== 64'h11) begin
                miscompares++; $display("FAIL data_first_data: got %h,%h required 22,11", rd_q[0], rd_q[1]);
            end
            vectors++;
            if (rd_cyc_q[0] != r + 1 + LAT || rd_cyc_q[1] != r + 2 + LAT) begin
                miscompares++;
                $display("FAIL data_first_timing: edges %0d,%0d required %0d,%0d", rd_cyc_q[0], rd_cyc_q[1], r + 1 + LAT, r + 2 + LAT);
            end
        end
        $display("data_first: data ahead of commands, reads 2 then 1");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a_tab [4];
        logic [DW-1:0] d_tab [4];
        int acc [4];
        a_tab = '{10'd5, 10'd1, 10'd2, 10'd5};
        d_tab = '{64'hA5A5, 64'h11, 64'h22, 64'hA5A5};
        clear_reads();
        for (int i = 0; i < 4; i++) send_cmd(CMD_READ, a_tab[i], acc[i]);
        repeat (10) step();
        vectors++;
        if (acc[3] != acc[0] + 3) begin
            miscompares++; $display("FAIL b2b_accept: last accept at edge %0d, required %0d", acc[3], acc[0] + 3);
        end
        vectors++;
        if (rd_q.size() != 4) begin
            miscompares++; $display("FAIL b2b_count: got %0d returns, required 4", rd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rd_q[i] !== d_tab[i] || rd_cyc_q[i] != acc[0] + 1 + LAT + i) begin
                    miscompares++;
                    $display("FAIL b2b_read%0d: got %h at edge %0d, required %h at edge %0d", i, rd_q[i], rd_cyc_q[i], d_tab[i], acc[0] + 1 + LAT + i);
                end
            end
        end
        $display("back_to_back: 4 reads accepted from edge %0d", acc[0]);
    endtask

    task automatic test_full();
        int acc;
        clear_reads();
        app_en = 1'b1; cmd = CMD_WRITE;
        for (int i = 0; i < 4; i++) begin
            addr = AW'(20 + i);
            vectors++;
            if (mem_app_rdy !== 1'b1) begin miscompares++; $display("FAIL full_accept%0d: app_rdy=%b, required 1", i, mem_app_rdy); end
            step();
        end
        addr = 10'd24;
        vectors++;
        if (mem_app_rdy !== 1'b0) begin miscompares++; $display("FAIL full_after4: app_rdy=%b, required 0", mem_app_rdy); end
        repeat (2) step();
        vectors++;
        if (mem_app_rdy !== 1'b0) begin miscompares++; $display("FAIL full_hold: app_rdy=%b, required 0", mem_app_rdy); end
        mem_wr = 1'b1; wr_data = 64'hF000_0000_0000_0000;
        step();
        mem_wr = 1'b0;
        vectors++;
        if (mem_app_rdy !== 1'b0) begin miscompares++; $display("FAIL full_data_pushed: app_rdy=%b, required 0", mem_app_rdy); end
        step();
        vectors++;
        if (mem_app_rdy !== 1'b1) begin miscompares++; $display("FAIL full_release: app_rdy=%b, required 1", mem_app_rdy); end
        step();
        app_en = 1'b0;
        for (int i = 1; i < 5; i++) send_data(64'hF000_0000_0000_0000 + DW'(i));
        for (int i = 0; i < 5; i++) send_cmd(CMD_READ, AW'(20 + i), acc);
        wait_reads(5);
        vectors++;
        if (rd_q.size() != 5) begin
            miscompares++; $display("FAIL full_count: got %0d returns, required 5", rd_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (rd_q[i] !== 64'hF000_0000_0000_0000 + DW'(i)) begin
                    miscompares++; $display("FAIL full_read%0d: got %h, required %h", i, rd_q[i], 64'hF000_0000_0000_0000 + DW'(i));
                end
            end
        end
        $display("full: 5 queued writes, data paired in order");
    endtask

    task automatic test_illegal();
        int acc;
        clear_reads();
        send_cmd(3'b111, 10'd0, acc);
        repeat (8) step();
        vectors++;
        if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: cmd_err=%b, required 1", cmd_err); end
        vectors++;
        if (rd_q.size() != 0) begin miscompares++; $display("FAIL illegal_no_read: got %0d returns, required 0", rd_q.size()); end
        send_cmd(CMD_READ, 10'd1, acc);
        wait_reads(1);
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 64'h11) begin
            miscompares++; $display("FAIL illegal_follow_read: got %0d returns first %h, required 1 of 11", rd_q.size(), rd_q.size() > 0 ? rd_q[0] : '0);
        end
        vectors++;
        if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: cmd_err=%b, required 1", cmd_err); end
        $display("illegal: cmd 111 flagged, later read served");
    endtask

    task automatic test_reset_midflight();
        int acc;
        clear_reads();
        send_cmd(CMD_READ, 10'd1, acc);
        send_cmd(CMD_READ, 10'd2, acc);
        rst = 1'b1;
        step();
        vectors++;
        if (mem_app_rdy !== 1'b0 || mem_wr_rdy !== 1'b0 || mem_rd_rdy !== 1'b0 || rd_data !== '0 || cmd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_rst_outputs: app=%b wr=%b rd=%b data=%h err=%b, required all 0", mem_app_rdy, mem_wr_rdy, mem_rd_rdy, rd_data, cmd_err);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (mem_app_rdy !== 1'b1) begin miscompares++; $display("FAIL midflight_release: app_rdy=%b, required 1", mem_app_rdy); end
        repeat (10) step();
        vectors++;
        if (rd_q.size() != 0) begin miscompares++; $display("FAIL midflight_dropped: got %0d returns, required 0", rd_q.size()); end
        send_cmd(CMD_READ, 10'd20, acc);
        wait_reads(1);
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 64'hF000_0000_0000_0000) begin
            miscompares++; $display("FAIL midflight_retained: got %0d returns first %h, required 1 of f000000000000000", rd_q.size(), rd_q.size() > 0 ? rd_q[0] : '0);
        end
        $display("reset_midflight: in-flight reads dropped, RAM retained");
    endtask

`ifdef MEM_RESP_REFRESH_EN
    task automatic test_refresh();
        int acc;
        int low_cnt = 0;
        logic tog = 1'b0;
        logic [DW-1:0] exp_q[$];
        send_cmd(CMD_WRITE, 10'd6, acc);
        send_data(64'h66);
        repeat (4) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        clear_reads();
        app_en = 1'b1; cmd = CMD_READ;
        for (int i = 0; i < 60; i++) begin
            addr = tog ? 10'd6 : 10'd5;
            if (mem_app_rdy) begin
                exp_q.push_back(tog ? 64'h66 : 64'hA5A5);
                tog = ~tog;
            end else begin
                low_cnt++;
            end
            step();
        end
        app_en = 1'b0;
        wait_reads(exp_q.size());
        vectors++;
        if (low_cnt < RCYC || low_cnt > RCYC + 3) begin
            miscompares++; $display("FAIL refresh_stall: app_rdy low %0d cycles, required %0d..%0d", low_cnt, RCYC, RCYC + 3);
        end
        vectors++;
        if (rd_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL refresh_count: got %0d returns, required %0d", rd_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (rd_q[i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL refresh_read%0d: got %h, required %h", i, rd_q[i], exp_q[i]);
                end
            end
        end
        $display("refresh: %0d reads, app_rdy low %0d cycles", exp_q.size(), low_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
`ifdef MEM_RESP_REFRESH_EN
        test_refresh();
`else
        test_data_first();
        test_back_to_back();
        test_full();
        test_illegal();
        test_reset_midflight();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Behavioural-RTL responder for the DDR application-side command interface driven by `mem_sched`. It accepts write/read commands and write data from the scheduler, stores data in an on-chip RAM, and returns read data after a fixed latency. It also emulates periodic refresh stalls. It replaces the DDR controller in simulation and in BRAM-only FPGA builds, so the optical-flow frame pipeline runs unchanged.

## Interface
Parameters:
- `ADDR_BITS`, 10: word address width; RAM depth is 2^ADDR_BITS.
- `DATA_WIDTH`, 64: data word width.
- `CMD_FIFO_DEPTH`, 4: command queue depth (power of 2).
- `WDF_DEPTH`, 4: write-data queue depth (power of 2).
- `RD_LATENCY`, 4: cycles from command execution to `mem_rd_rdy` (≥1).
- `REFRESH_PERIOD`, 1024: cycles between refresh stalls.
- `REFRESH_CYCLES`, 16: stall length.

Ports (clock and reset):
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.

Ports (command and data):
- `app_en`  in  1  command valid.
- `cmd`  in  3  3'b000 write, 3'b001 read; other values are illegal.
- `addr`  in  ADDR_BITS  word address, sampled with `app_en`.
- `mem_wr`  in  1  write-data valid.
- `wr_data`  in  DATA_WIDTH  write data.
- `mem_app_rdy`  out  1  command accepted when `app_en & mem_app_rdy`.
- `mem_wr_rdy`  out  1  data accepted when `mem_wr & mem_wr_rdy`.
- `mem_rd_rdy`  out  1  read data valid, single cycle, no backpressure.
- `rd_data`  out  DATA_WIDTH  read data; 0 when not valid.
- `cmd_err`  out  1  sticky; set when an illegal command is accepted.

## Operation
- Command queue stores {cmd, addr}. Write-data queue stores wr_data. `mem_app_rdy` = !cmd_full & !refresh_block. `mem_wr_rdy` = !wdf_full. Both readies come from registered state only, with no combinational path from inputs.
- Executor FSM states:
  - IDLE: pop the queue head if non-empty.
    - Write head with WDF non-empty: pop both and write RAM[addr] in the same cycle.
    - Write head with WDF empty: go to WAIT_WD; the head is not popped.
    - Read head: pop and issue the RAM read.
    - Illegal head: pop, discard, and set `cmd_err`.
    - Go to REFRESH if refresh is due and no command is popped.
  - WAIT_WD: when WDF becomes non-empty, pop both, perform the write, and return to IDLE.
  - REFRESH: hold for REFRESH_CYCLES with no pops, then clear the due flag and return to IDLE.
- Execution is in order, at most one command per cycle. Read-after-write to the same address returns the new data.
- Write data may arrive before or after its command. Data pairs with commands strictly by order.
- Read pipeline is a valid/data shift register of RD_LATENCY stages. It is independent of refresh, so in-flight reads still complete.
- Refresh counter counts 0..REFRESH_PERIOD-1 and wraps. On wrap it sets refresh_due. `refresh_block` (drop `mem_app_rdy`) asserts from refresh_due until REFRESH exits.
- Queue counters are $clog2(depth)+1 bits. Pointers wrap modulo depth. Push on a full queue never happens because the readies gate it. Push and pop in the same cycle leave the count unchanged.
- Reset:
  - Flushes both queues, pipeline valids, the FSM (to IDLE), the refresh counter, and `cmd_err`.
  - RAM contents are retained.
  - A mid-operation reset drops all queued and in-flight transactions. No `mem_rd_rdy` is issued for them.
- Output values during `rst`: `mem_app_rdy`=0, `mem_wr_rdy`=0, `mem_rd_rdy`=0, `rd_data`=0, `cmd_err`=0. Readies rise the cycle after `rst` deasserts.

## Timing
- Command accepted at edge T. The earliest execution is T+1.
- Read accepted at T with an empty queue gives `mem_rd_rdy` at T+1+RD_LATENCY.
- A write becomes visible to a read executed at T+2 or later.
- Back-to-back commands sustain one per cycle with no refresh. A write needs matching WDF data.
- The refresh stall takes effect the cycle after refresh_due is set. The command accepted on that edge is still queued.

## Configuration
- `MEM_RESP_REFRESH_EN` defined: refresh counter, refresh_due, and the REFRESH state are compiled in, as described above.
- Undefined: no refresh logic. `mem_app_rdy` = !cmd_full. The REFRESH state is unreachable and removed, and REFRESH_PERIOD and REFRESH_CYCLES are ignored.

## Structure
- Shared package `mem_if_pkg` holds:
  - CMD_WRITE = 3'b000, CMD_READ = 3'b001;
  - the executor state encoding (IDLE, WAIT_WD, REFRESH);
  - the `is_legal_cmd` function. `mem_sched` also imports the cmd constants.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated for the command queue and the WDF.
- RAM is inferred inline as a single-port write with registered read.

## Test plan
- Write 0xA5A5 to addr 5 (cmd then data), then read addr 5 → `mem_rd_rdy` one cycle with `rd_data`=0xA5A5, 1+RD_LATENCY cycles after read acceptance.
- Data 0x11, 0x22 sent before write commands to addrs 1 and 2, then reads of addrs 2 and 1 → 0x22 then 0x11 on consecutive cycles.
- 5 writes with no data and `app_en` held → `mem_app_rdy` low after 4 accepted. It rises the cycle after the first data word is consumed.
- With `MEM_RESP_REFRESH_EN`, REFRESH_PERIOD=32: continuous reads → `mem_app_rdy` low for REFRESH_CYCLES around cycle 32. No reads lost; data order preserved.
- Accept cmd=3'b111 → `cmd_err`=1 stays set, no `mem_rd_rdy`. A subsequent read is still served.
- Assert `rst` with 2 reads in flight → no `mem_rd_rdy` after reset. `cmd_err`=0. Data written earlier is readable after reset.
